// File: rtl/eightbit_pkg.sv
// eightbit_pkg: shared types and constants for the eightbit memory side.
// Used by eightbit_ram and eightbit_ram_loader.
package eightbit_pkg;

    typedef enum logic {
        RAM_LOAD = 1'b0,
        RAM_RUN  = 1'b1
    } ram_state_t;

    localparam logic [7:0] EIGHTBIT_IO_ADDR_DEFAULT = 8'hFF;
    localparam int         EIGHTBIT_MEM_DEPTH       = 256;

endpackage

// File: rtl/eightbit_ram_loader.sv
// eightbit_ram_loader: LOAD/RUN sequencer, load pointer and image length.
// Accepts one byte per cycle until load_last or the 256th byte.
module eightbit_ram_loader
    import eightbit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    input  logic       load_last,
    output logic       load_ready,
    output logic       load_we,
    output logic [7:0] load_addr,
    output logic       cpu_run,
    output logic [8:0] prog_len
);

    ram_state_t state;
    ram_state_t state_nxt;
    logic [7:0] ptr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RAM_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs, all decoded from registered state
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        cpu_run    = 1'b0;
        unique case (state)
            RAM_LOAD: begin
                load_ready = 1'b1;
                if (load_valid && (load_last || ptr == 8'hFF)) begin
                    state_nxt = RAM_RUN;
                end
            end
            RAM_RUN: begin
                cpu_run = 1'b1;
            end
            default: begin
                state_nxt = RAM_LOAD;
            end
        endcase
    end

    assign load_we   = load_valid & load_ready;
    assign load_addr = ptr;

    // Pointer and length advance only on accepted bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 8'h00;
            prog_len <= 9'd0;
        end else if (load_we) begin
            ptr      <= ptr + 8'd1;
            prog_len <= prog_len + 9'd1;
        end
    end

endmodule

// File: rtl/eightbit_ram.sv
// eightbit_ram: 256x8 CPU RAM with byte-stream loader and one output port.
// Define EIGHTBIT_RAM_WP_EN to write-protect the loaded image region.
module eightbit_ram
    import eightbit_pkg::*;
#(
    parameter logic [7:0] IO_ADDR = EIGHTBIT_IO_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] rdata,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       cpu_run,
    output logic [7:0] io_out,
    output logic       wp_err
);

    logic [7:0] mem [EIGHTBIT_MEM_DEPTH];
    logic       load_we;
    logic [7:0] load_addr;
    logic [8:0] prog_len;
    logic       cpu_we;

    eightbit_ram_loader u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .cpu_run    (cpu_run),
        .prog_len   (prog_len)
    );

`ifdef EIGHTBIT_RAM_WP_EN
    logic wp_hit;

    assign wp_hit = cpu_run & we & ({1'b0, addr} < prog_len);
    assign cpu_we = cpu_run & we & ~wp_hit;

    // Sticky flag for any dropped write into the image region
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_err <= 1'b0;
        end else if (wp_hit) begin
            wp_err <= 1'b1;
        end
    end
`else
    logic unused_prog_len;

    assign unused_prog_len = ^prog_len;
    assign cpu_we          = cpu_run & we;
    assign wp_err          = 1'b0;
`endif

    // Array write port: loader owns it in LOAD, CPU in RUN
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end else if (cpu_we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register tracks CPU writes to IO_ADDR only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_out <= 8'h00;
        end else if (cpu_we && addr == IO_ADDR) begin
            io_out <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule
